pwm_shadow_bank: RTL and testbench

Multi-channel, double-buffered shadow register bank for the PWM datapath, generalising the single 16-bit mask register. Software-side writes land in per-channel staging registers. A commit arms the bank. All channels then transfer atomically to the active outputs on the Nth qualifying mask event, so a multi-register update (period, duty, dead-time) never straddles a PWM cycle. While the PWM is off, the active registers track staging directly.

---
 rtl/pwm_shadow_bank.sv | 128 ++++++++++++
 tb/tb_pwm_shadow_bank.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_shadow_bank.sv
// pwm_shadow_bank: double-buffered multi-channel shadow register bank.
// Writes land in staging. A commit arms the bank. On the Nth mask event all
// channels move to the active outputs together. With the PWM off, the active
// registers follow staging on every edge.

package PKG_pwm;
  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;
endpackage

module pwm_shadow_bank
  import PKG_pwm::*;
#(
  parameter int                 WIDTH       = 16,
  parameter int                 CHANNELS    = 4,
  parameter int                 DIV_W       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                CHAN_W      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  _pwm_onoff                 pwm_onoff,
  input  logic                      mask_event,
  input  logic                      wr_en,
  input  logic [CHAN_W-1:0]         wr_chan,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      commit,
  input  logic [DIV_W-1:0]          event_div,
  output logic [CHANNELS*WIDTH-1:0] reg_out,
  output logic                      pending,
  output logic                      update_done,
  output logic [CHANNELS-1:0]       dirty,
  output logic                      wr_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // One extra bit so that CHANNELS itself is representable when it is a
  // power of two; the range check then folds to "always in range".
  localparam logic [CHAN_W:0] CHAN_LIMIT = CHANNELS[CHAN_W:0];

  state_e                      state_q;
  logic [DIV_W-1:0]            count_q;
  logic [CHANNELS*WIDTH-1:0]   staging_q;
  logic [CHANNELS*WIDTH-1:0]   staging_d;
  logic [CHANNELS*WIDTH-1:0]   regOut_q;
  logic [CHANNELS-1:0]         dirty_q;
  logic                        updateDone_q;
  logic                        wrErr_q;

  logic                        chanInRange;
  logic                        locked;
  logic                        wrAccept;
  logic                        wrReject;

  // Decode the write: staging is locked only while armed with the PWM running.
  always_comb begin
    chanInRange = ({1'b0, wr_chan} < CHAN_LIMIT);
    locked      = (state_q == ARMED) && (pwm_onoff == PWM_ON);
    wrAccept    = wr_en && chanInRange && !locked;
    wrReject    = wr_en && !wrAccept;
    staging_d   = staging_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wrAccept && (wr_chan == CHAN_W'(c))) begin
        staging_d[c*WIDTH +: WIDTH] = wr_data;
      end
    end
  end

  // Arm/transfer state machine together with the staging and active banks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      staging_q    <= {CHANNELS{RESET_VALUE}};
      regOut_q     <= {CHANNELS{RESET_VALUE}};
      dirty_q      <= '0;
      updateDone_q <= 1'b0;
      wrErr_q      <= 1'b0;
    end else begin
      updateDone_q <= 1'b0;
      wrErr_q      <= wrReject;
      staging_q    <= staging_d;
      if (pwm_onoff == PWM_OFF) begin
        state_q  <= IDLE;
        count_q  <= '0;
        dirty_q  <= '0;
        regOut_q <= staging_d;
      end else begin
        case (state_q)
          IDLE: begin
            if (wrAccept) begin
              dirty_q[wr_chan] <= 1'b1;
            end
            if (commit) begin
              state_q <= ARMED;
              count_q <= event_div;
            end
          end
          ARMED: begin
            if (mask_event) begin
              if (count_q != '0) begin
                count_q <= count_q - DIV_W'(1);
              end else begin
                regOut_q     <= staging_q;
                dirty_q      <= '0;
                updateDone_q <= 1'b1;
                state_q      <= IDLE;
              end
            end
          end
        endcase
      end
    end
  end

  assign reg_out     = regOut_q;
  assign pending     = (state_q == ARMED);
  assign update_done = updateDone_q;
  assign dirty       = dirty_q;
  assign wr_err      = wrErr_q;

endmodule

// File: tb/tb_pwm_shadow_bank.sv
// tb_pwm_shadow_bank: randomized and directed stimulus for pwm_shadow_bank,
// with expected outputs queued by a reference model and checked by a monitor.

module tb_pwm_shadow_bank;
  import PKG_pwm::*;

  localparam int               W    = 16;
  localparam int               CH   = 5;
  localparam int               DW   = 8;
  localparam int               CW   = $clog2(CH);
  localparam logic [W-1:0]     RV   = 16'hA5A5;

  typedef struct packed {
    logic [CH*W-1:0] regOut;
    logic            pending;
    logic            done;
    logic [CH-1:0]   dirty;
    logic            err;
  } expect_t;

  logic              clk;
  logic              reset;
  _pwm_onoff         pwmOnoff;
  logic              maskEvent;
  logic              wrEn;
  logic [CW-1:0]     wrChan;
  logic [W-1:0]      wrData;
  logic              commitIn;
  logic [DW-1:0]     eventDiv;
  logic [CH*W-1:0]   regOut;
  logic              pending;
  logic              updateDone;
  logic [CH-1:0]     dirty;
  logic              wrErr;

  int total = 0;
  int bad   = 0;

  expect_t expQ[$];

  // Reference model: per-channel arrays plus an armed flag and events-left.
  logic [W-1:0] mStage  [CH];
  logic [W-1:0] mActive [CH];
  bit           mDirty  [CH];
  bit           mArmed;
  int           mLeft;
  bit           mDone;
  bit           mErr;

  pwm_shadow_bank #(
    .WIDTH(W),
    .CHANNELS(CH),
    .DIV_W(DW),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pwm_onoff(pwmOnoff),
    .mask_event(maskEvent),
    .wr_en(wrEn),
    .wr_chan(wrChan),
    .wr_data(wrData),
    .commit(commitIn),
    .event_div(eventDiv),
    .reg_out(regOut),
    .pending(pending),
    .update_done(updateDone),
    .dirty(dirty),
    .wr_err(wrErr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic expect_t modelSnapshot();
    expect_t e;
    for (int c = 0; c < CH; c++) begin
      e.regOut[c*W +: W] = mActive[c];
      e.dirty[c]         = mDirty[c];
    end
    e.pending = mArmed;
    e.done    = mDone;
    e.err     = mErr;
    return e;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < CH; c++) begin
      mStage[c]  = RV;
      mActive[c] = RV;
      mDirty[c]  = 1'b0;
    end
    mArmed = 1'b0;
    mLeft  = 0;
    mDone  = 1'b0;
    mErr   = 1'b0;
  endtask

  task automatic modelStep(input bit on, input bit ev, input bit we, input int ch,
                           input logic [W-1:0] data, input bit cm, input int div);
    mDone = 1'b0;
    mErr  = 1'b0;
    if (!on) begin
      if (we) begin
        if (ch < CH) mStage[ch] = data;
        else mErr = 1'b1;
      end
      for (int c = 0; c < CH; c++) begin
        mActive[c] = mStage[c];
        mDirty[c]  = 1'b0;
      end
      mArmed = 1'b0;
      mLeft  = 0;
    end else if (!mArmed) begin
      if (we) begin
        if (ch < CH) begin
          mStage[ch] = data;
          mDirty[ch] = 1'b1;
        end else begin
          mErr = 1'b1;
        end
      end
      if (cm) begin
        mArmed = 1'b1;
        mLeft  = div;
      end
    end else begin
      if (we) mErr = 1'b1;
      if (ev) begin
        if (mLeft > 0) begin
          mLeft = mLeft - 1;
        end else begin
          for (int c = 0; c < CH; c++) begin
            mActive[c] = mStage[c];
            mDirty[c]  = 1'b0;
          end
          mDone  = 1'b1;
          mArmed = 1'b0;
        end
      end
    end
  endtask

  task automatic compareField(input string name, input logic [CH*W-1:0] got,
                              input logic [CH*W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    compareField("reg_out", regOut, e.regOut);
    compareField("pending", {{(CH*W-1){1'b0}}, pending}, {{(CH*W-1){1'b0}}, e.pending});
    compareField("update_done", {{(CH*W-1){1'b0}}, updateDone}, {{(CH*W-1){1'b0}}, e.done});
    compareField("dirty", {{(CH*W-CH){1'b0}}, dirty}, {{(CH*W-CH){1'b0}}, e.dirty});
    compareField("wr_err", {{(CH*W-1){1'b0}}, wrErr}, {{(CH*W-1){1'b0}}, e.err});
  endtask

  // One cycle of stimulus: drive at the falling edge, queue the expectation.
  task automatic applyStimulus(input bit on, input bit ev, input bit we, input int ch,
                               input logic [W-1:0] data, input bit cm, input int div);
    @(negedge clk);
    reset     = 1'b1;
    pwmOnoff  = on ? PWM_ON : PWM_OFF;
    maskEvent = ev;
    wrEn      = we;
    wrChan    = ch[CW-1:0];
    wrData    = data;
    commitIn  = cm;
    eventDiv  = div[DW-1:0];
    modelStep(on, ev, we, ch, data, cm, div);
    expQ.push_back(modelSnapshot());
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, hold for n edges.
  task automatic applyReset(input int n);
    @(negedge clk);
    reset     = 1'b0;
    maskEvent = 1'b0;
    wrEn      = 1'b0;
    commitIn  = 1'b0;
    #1;
    modelReset();
    checkOutput(modelSnapshot());
    expQ.push_back(modelSnapshot());
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      expQ.push_back(modelSnapshot());
    end
  endtask

  // Monitor: after each rising edge, pop the expectation for that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    reset     = 1'b0;
    pwmOnoff  = PWM_ON;
    maskEvent = 1'b0;
    wrEn      = 1'b0;
    wrChan    = '0;
    wrData    = '0;
    commitIn  = 1'b0;
    eventDiv  = '0;
    modelReset();

    applyReset(3);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);

    // single transfer
    applyStimulus(1, 0, 1, 0, 16'h1234, 0, 0);
    applyStimulus(1, 0, 1, 3, 16'hBEEF, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 1, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);

    // divider of two
    applyStimulus(1, 0, 1, 2, 16'h2222, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 1, 2);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 7);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);

    // lock while armed, out-of-range channels in idle
    applyStimulus(1, 0, 0, 0, 16'h0, 1, 0);
    applyStimulus(1, 0, 1, 1, 16'h5555, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 1, CH, 16'h7777, 0, 0);
    applyStimulus(1, 0, 1, 7, 16'h8888, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);

    // transparent mode, then dropping to off while armed
    applyStimulus(0, 0, 1, 2, 16'h00FF, 0, 0);
    applyStimulus(0, 0, 0, 0, 16'h0, 1, 0);
    applyStimulus(1, 0, 1, 4, 16'h4444, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 1, 3);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);

    // coincident commit and event, write with commit, re-arm on done
    applyStimulus(1, 1, 1, 1, 16'h1111, 1, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 1, 0, 16'hCAFE, 1, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);

    // reset while armed
    applyStimulus(1, 0, 1, 3, 16'h3333, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0, 1, 1);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyReset(2);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset(1);
      end else begin
        applyStimulus($urandom_range(0, 9) != 0,
                      $urandom_range(0, 9) < 3,
                      $urandom_range(0, 9) < 4,
                      int'($urandom_range(0, 7)),
                      W'($urandom),
                      $urandom_range(0, 9) < 2,
                      int'($urandom_range(0, 3)));
      end
    end

    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d queued expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
